// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port-per-direction 32-word data memory between the CPU
// load/store path (master 0) and the UART debug/loader bridge (master 1).
// Each cycle at most one access per master is accepted. Conflicts are resolved
// round-robin. A master may lock the bus for multi-word transfers. Read data
// from the memory (one-cycle registered latency) is steered back to the
// master that issued the read.
//
// Optional feature: define DMEM_ARB_DUAL_EN to let a read from one master and
// a write from the other proceed in the same cycle (read port + write port).
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   mN_req/we/lock/addr/wdata  master N request channel (N = 0, 1)
//   mN_gnt                     combinational grant, access done this cycle
//   mN_rvalid/rdata            read response, one cycle after a read grant
//   mem_read_addr              memory read address (0 when no read)
//   mem_write_addr/data, mem_sw memory write port (0 when no write)
//   mem_read_data              registered read data from memory
// -----------------------------------------------------------------------------
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [4:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [4:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic [4:0]  mem_read_addr,
  output logic [4:0]  mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_sw,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } lock_state_e;

  lock_state_e state_q, state_d;
  logic        last_gnt_q, last_gnt_d;   // 0 = master 0 won last, 1 = master 1
  logic        rd_valid_q, rd_valid_d;   // a read was granted last cycle
  logic        rd_owner_q, rd_owner_d;   // which master issued that read

  logic        hold0, hold1;
  logic        gnt0, gnt1;
  logic        dual;
  logic        rw_split;

  // A read and a write from different masters can share the cycle only when
  // the dual-port feature is built in.
`ifdef DMEM_ARB_DUAL_EN
  assign rw_split = (m0_we != m1_we);
`else
  assign rw_split = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration, lock FSM next state and memory port steering.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned; otherwise synthesis infers a latch.
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    dual           = 1'b0;
    state_d        = state_q;
    last_gnt_d     = last_gnt_q;
    rd_valid_d     = 1'b0;
    rd_owner_d     = rd_owner_q;
    mem_read_addr  = 5'd0;
    mem_write_addr = 5'd0;
    mem_write_data = 32'd0;
    mem_sw         = 1'b0;

    // The owner keeps the bus only while it still requests with lock high.
    // Once it drops either, this same cycle is arbitrated as if idle.
    hold0 = (state_q == ST_OWN0) && m0_req && m0_lock;
    hold1 = (state_q == ST_OWN1) && m1_req && m1_lock;

    if (reset) begin
      // No grants while reset is asserted.
    end else if (hold0) begin
      gnt0 = 1'b1;
    end else if (hold1) begin
      gnt1 = 1'b1;
    end else if (m0_req && m1_req) begin
      if (rw_split) begin
        gnt0 = 1'b1;
        gnt1 = 1'b1;
        dual = 1'b1;
      end else if (last_gnt_q) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = m0_req;
      gnt1 = m1_req;
    end

    // Round-robin pointer follows the single winner; a shared read/write
    // cycle favours nobody, so the pointer stays put.
    if (!dual) begin
      if (gnt0)      last_gnt_d = 1'b0;
      else if (gnt1) last_gnt_d = 1'b1;
    end

    if (gnt0 && m0_lock)      state_d = ST_OWN0;
    else if (gnt1 && m1_lock) state_d = ST_OWN1;
    else                      state_d = ST_IDLE;

    // Both grants at once only happen for a read/write split, so the two
    // masters never collide on the same memory port here.
    if (gnt0) begin
      if (m0_we) begin
        mem_write_addr = m0_addr;
        mem_write_data = m0_wdata;
        mem_sw         = 1'b1;
      end else begin
        mem_read_addr  = m0_addr;
        rd_valid_d     = 1'b1;
        rd_owner_d     = 1'b0;
      end
    end
    if (gnt1) begin
      if (m1_we) begin
        mem_write_addr = m1_addr;
        mem_write_data = m1_wdata;
        mem_sw         = 1'b1;
      end else begin
        mem_read_addr  = m1_addr;
        rd_valid_d     = 1'b1;
        rd_owner_d     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. last_gnt resets to 1 so master 0 wins the first conflict.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    if (reset) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Outputs. rvalid is masked during reset so a read granted just before a
  // reset never returns data (the memory clears its read register anyway).
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rd_valid_q && !rd_owner_q && !reset;
  assign m1_rvalid = rd_valid_q &&  rd_owner_q && !reset;
  assign m0_rdata  = m0_rvalid ? mem_read_data : 32'd0;
  assign m1_rdata  = m1_rvalid ? mem_read_data : 32'd0;

endmodule
